// File: rtl/imem_loader.sv
// imem_loader: packs host words into instruction lines,
// writes them to the instruction SRAM and releases PURGE.
module imem_loader #(
  parameter int ADDR_W    = 14,
  parameter int LINE_W    = 128,
  parameter int WORD_W    = 32,
  parameter int DRAIN_CYC = 2
) (
  input  logic              CLK,
  input  logic              RSTL,
  input  logic              START,
  input  logic [ADDR_W:0]   LEN,
  input  logic              S_VALID,
  input  logic [WORD_W-1:0] S_DATA,
  output logic              S_READY,
  output logic [ADDR_W-1:0] WADDRI,
  output logic [LINE_W-1:0] DI,
  output logic              WCEBI,
  output logic              PURGE,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR
);

  localparam int NW = LINE_W / WORD_W;
  localparam int IW = $clog2(NW);
  localparam int DW = $clog2(DRAIN_CYC + 1);
  localparam logic [ADDR_W:0] MAX_LEN =
    {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [2:0] {
    HALT, LOAD, WRITE, DRAIN, RUN
  } state_t;

  state_t state, state_n;

  logic [ADDR_W:0]          len_q;
  logic [ADDR_W:0]          lcnt;
  logic [ADDR_W:0]          lcnt_inc;
  logic [ADDR_W-1:0]        addr;
  logic [IW-1:0]            widx;
  logic [DW-1:0]            dcnt;
  logic [LINE_W-WORD_W-1:0] lbuf;
  logic                     accept;
  logic                     last_word;
  logic                     len_ok;
  logic                     go;
  logic                     err_n;
  logic                     done_n;

  assign S_READY  = (state == LOAD);
  assign BUSY     = state inside {LOAD, WRITE, DRAIN};
  assign PURGE    = (state != RUN);
  assign lcnt_inc = lcnt + 1'b1;

  always_ff @(posedge CLK or negedge RSTL) begin
    if (!RSTL) state <= HALT;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    err_n     = 1'b0;
    done_n    = 1'b0;
    go        = 1'b0;
    len_ok    = (LEN != '0) && (LEN <= MAX_LEN);
    accept    = S_VALID && (state == LOAD);
    last_word = accept && (widx == IW'(NW - 1));
    unique case (state)
      HALT, RUN: begin
        if (START) begin
          if (len_ok) begin
            go      = 1'b1;
            state_n = LOAD;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      LOAD: begin
        err_n = START;
        if (last_word) state_n = WRITE;
      end
      WRITE: begin
        err_n = START;
        if (lcnt_inc == len_q) state_n = DRAIN;
        else                   state_n = LOAD;
      end
      DRAIN: begin
        err_n = START;
        if (dcnt == DW'(DRAIN_CYC - 1)) begin
          state_n = RUN;
          done_n  = 1'b1;
        end
      end
      default: state_n = HALT;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTL) begin
    if (!RSTL) begin
      len_q  <= '0;
      lcnt   <= '0;
      addr   <= '0;
      widx   <= '0;
      dcnt   <= '0;
      lbuf   <= '0;
      DI     <= '0;
      WADDRI <= '0;
      WCEBI  <= 1'b1;
      DONE   <= 1'b0;
      ERR    <= 1'b0;
    end else begin
      DONE  <= done_n;
      ERR   <= err_n;
      WCEBI <= (state_n != WRITE);
      dcnt  <= (state == DRAIN) ? dcnt + 1'b1 : '0;
      if (go) begin
        len_q <= LEN;
        lcnt  <= '0;
        addr  <= '0;
        widx  <= '0;
      end
      if (accept) begin
        widx <= widx + 1'b1;
        for (int k = 0; k < NW - 1; k++)
          if (widx == IW'(k))
            lbuf[k*WORD_W +: WORD_W] <= S_DATA;
      end
      // the final word goes straight into DI with the buffered rest
      if (last_word) begin
        DI     <= {S_DATA, lbuf};
        WADDRI <= addr;
      end
      if (state == WRITE) begin
        addr <= addr + 1'b1;
        lcnt <= lcnt_inc;
        widx <= '0;
      end
    end
  end

endmodule
